comm_recv_sched: RTL

//  Receive-side frame scheduler between the AD interface and the rescale/fftfifo/fft64 chain.

---
 rtl/comm_pkg.sv | 21 ++
 rtl/comm_recv_sched_if.sv | 27 ++
 rtl/comm_energy_det.sv | 38 +++
 rtl/comm_recv_sched.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared definitions for the receive-side scheduler: FFT block size, AD zero level,
// FSM state encoding and the offset-binary magnitude helper.
package comm_pkg;

  localparam int         FFT_N   = 64;
  localparam logic [7:0] AD_ZERO = 8'h80;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT    = 3'd1,
    SKIP_CP = 3'd2,
    DATA    = 3'd3,
    DROP    = 3'd4
  } state_t;

  // Distance of an offset-binary sample from zero; 8'h00 gives 128, which still fits 8 bits.
  function automatic logic [7:0] ad_mag(input logic [7:0] x);
    return (x >= AD_ZERO) ? (x - AD_ZERO) : (AD_ZERO - x);
  endfunction

endpackage

// File: rtl/comm_recv_sched_if.sv
// Sample-path bundle between the AD front end, the scheduler and the downstream fftfifo.
//
// Handshake: ad_valid qualifies ad1/ad2 for exactly one cycle and the scheduler always
// accepts (there is no ready). valid_o qualifies ad1o/ad2o for one cycle and sym_start is
// only ever high together with valid_o. fifo_full is a level that the scheduler samples once
// per symbol, on the last cyclic-prefix sample; it never stalls a symbol already in flight.
interface comm_recv_sched_if;
  logic [7:0] ad1;
  logic [7:0] ad2;
  logic       ad_valid;
  logic       fifo_full;
  logic [7:0] ad1o;
  logic [7:0] ad2o;
  logic       valid_o;
  logic       sym_start;
  logic       frame_done;

  modport master (
    input  ad1, ad2, ad_valid, fifo_full,
    output ad1o, ad2o, valid_o, sym_start, frame_done
  );

  modport slave (
    output ad1, ad2, ad_valid, fifo_full,
    input  ad1o, ad2o, valid_o, sym_start, frame_done
  );
endinterface

// File: rtl/comm_energy_det.sv
// Frame-start detector: |ad1-0x80|+|ad2-0x80| compared against THRESH, with a run-length
// counter that raises trigger on the HOLD-th consecutive above-threshold sample.
module comm_energy_det
  import comm_pkg::*;
#(
  parameter int THRESH = 40,
  parameter int HOLD   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hunting,
  input  logic       ad_valid,
  input  logic [7:0] ad1,
  input  logic [7:0] ad2,
  output logic       trigger
);

  logic [8:0] energy;
  logic       above;
  logic [3:0] run_cnt;

  assign energy  = {1'b0, ad_mag(ad1)} + {1'b0, ad_mag(ad2)};
  assign above   = energy > 9'(THRESH);
  assign trigger = hunting && ad_valid && above && (run_cnt == 4'(HOLD - 1));

  // The run only accumulates while hunting, so every hunt starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= 4'd0;
    end else if (!hunting) begin
      run_cnt <= 4'd0;
    end else if (ad_valid) begin
      if (!above || trigger) run_cnt <= 4'd0;
      else                   run_cnt <= run_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/comm_recv_sched.sv
// Receive frame scheduler: energy-detected frame start, CP stripping, whole-symbol forwarding
// or dropping. Optional statistics counters under COMM_RECV_SCHED_STATS_EN.
module comm_recv_sched
  import comm_pkg::*;
#(
  parameter int CP_LEN = 16,
  parameter int THRESH = 40,
  parameter int HOLD   = 4,
  parameter int NSYM_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic [NSYM_W-1:0] nsym,
  comm_recv_sched_if.master bus,
  output logic              busy,
  output logic              overflow,
  output state_t            state_dbg
`ifdef COMM_RECV_SCHED_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  state_t            state, state_n;
  logic [5:0]        samp_cnt, samp_n;
  logic [NSYM_W-1:0] sym_cnt, sym_n, nsym_lat, nsym_lat_n, sym_inc;
  logic [7:0]        ad1o_q, ad2o_q, ad1o_n, ad2o_n;
  logic              valid_q, valid_n, sym_start_q, sym_start_n;
  logic              fd_pend_q, fd_pend_n, frame_done_q;
  logic              overflow_q, overflow_n;
  logic              trigger, cp_last, sym_last, drop_evt;

  comm_energy_det #(.THRESH(THRESH), .HOLD(HOLD)) u_energy_det (
    .clk      (CLK),
    .rst_n    (RST),
    .hunting  (state == HUNT && enable),
    .ad_valid (bus.ad_valid),
    .ad1      (bus.ad1),
    .ad2      (bus.ad2),
    .trigger  (trigger)
  );

  assign sym_inc  = sym_cnt + NSYM_W'(1);
  assign drop_evt = cp_last && bus.fifo_full;

  always_comb begin
    state_n     = state;
    samp_n      = samp_cnt;
    sym_n       = sym_cnt;
    nsym_lat_n  = nsym_lat;
    ad1o_n      = ad1o_q;
    ad2o_n      = ad2o_q;
    valid_n     = 1'b0;
    sym_start_n = 1'b0;
    fd_pend_n   = 1'b0;
    overflow_n  = enable ? overflow_q : 1'b0;
    cp_last     = 1'b0;
    sym_last    = 1'b0;

    case (state)
      IDLE: if (enable) state_n = HUNT;
      HUNT: begin
        samp_n = 6'd0;
        if (!enable) begin
          state_n = IDLE;
        end else if (trigger) begin
          nsym_lat_n = (nsym == '0) ? NSYM_W'(1) : nsym;
          sym_n      = '0;
          // The triggering sample is CP sample 0.
          if (CP_LEN == 1) begin
            cp_last = 1'b1;
          end else begin
            state_n = SKIP_CP;
            samp_n  = 6'd1;
          end
        end
      end
      SKIP_CP: if (bus.ad_valid) begin
        if (samp_cnt == 6'(CP_LEN - 1)) cp_last = 1'b1;
        else                            samp_n  = samp_cnt + 6'd1;
      end
      DATA: if (bus.ad_valid) begin
        ad1o_n      = bus.ad1;
        ad2o_n      = bus.ad2;
        valid_n     = 1'b1;
        sym_start_n = (samp_cnt == 6'd0);
        if (samp_cnt == 6'(FFT_N - 1)) sym_last = 1'b1;
        else                           samp_n   = samp_cnt + 6'd1;
      end
      DROP: if (bus.ad_valid) begin
        if (samp_cnt == 6'(FFT_N - 1)) sym_last = 1'b1;
        else                           samp_n   = samp_cnt + 6'd1;
      end
      default: state_n = IDLE;
    endcase

    // fifo_full is only consulted here, so a symbol is either forwarded or dropped whole.
    if (cp_last) begin
      samp_n = 6'd0;
      if (bus.fifo_full) begin
        state_n    = DROP;
        overflow_n = 1'b1;
      end else begin
        state_n = DATA;
      end
    end

    if (sym_last) begin
      samp_n = 6'd0;
      sym_n  = sym_inc;
      if (sym_inc == nsym_lat) begin
        fd_pend_n = 1'b1;
        state_n   = enable ? HUNT : IDLE;
      end else begin
        state_n = enable ? SKIP_CP : IDLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      samp_cnt     <= 6'd0;
      sym_cnt      <= '0;
      nsym_lat     <= '0;
      ad1o_q       <= 8'd0;
      ad2o_q       <= 8'd0;
      valid_q      <= 1'b0;
      sym_start_q  <= 1'b0;
      fd_pend_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state        <= state_n;
      samp_cnt     <= samp_n;
      sym_cnt      <= sym_n;
      nsym_lat     <= nsym_lat_n;
      ad1o_q       <= ad1o_n;
      ad2o_q       <= ad2o_n;
      valid_q      <= valid_n;
      sym_start_q  <= sym_start_n;
      fd_pend_q    <= fd_pend_n;
      frame_done_q <= fd_pend_q;
      overflow_q   <= overflow_n;
    end
  end

`ifdef COMM_RECV_SCHED_STATS_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_cnt <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      if (fd_pend_n && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (drop_evt && drop_cnt != 16'hFFFF)   drop_cnt  <= drop_cnt + 16'd1;
    end
  end
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
`endif

  assign bus.ad1o       = ad1o_q;
  assign bus.ad2o       = ad2o_q;
  assign bus.valid_o    = valid_q;
  assign bus.sym_start  = sym_start_q;
  assign bus.frame_done = frame_done_q;
  assign overflow       = overflow_q;
  assign busy           = (state == SKIP_CP) || (state == DATA) || (state == DROP);
  assign state_dbg      = state;

endmodule
